// File: rtl/inst_decode_stage_pkg.sv
// Shared definitions for the instruction decode stage: opcode constants,
// the R-type opcode list, the branch-class predicate and the FSM states.
package inst_decode_stage_pkg;

  localparam logic [5:0] OPC_ALU  = 6'd0;
  localparam logic [5:0] OPC_BEQ  = 6'd16;
  localparam logic [5:0] OPC_LOAD = 6'd32;
  localparam logic [5:0] OPC_HALT = 6'd63;

  localparam int N_RTYPE = 10;
  localparam logic [5:0] RTYPE_OPCS [N_RTYPE] = '{
    6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14
  };

  // Register-register class: membership in the fixed opcode list.
  function automatic logic is_rtype(input logic [5:0] opc);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_RTYPE; i++) begin
      if (opc == RTYPE_OPCS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Branch class: the whole 16..31 opcode block plus low nibbles 10, 11, 15.
  function automatic logic is_branch(input logic [5:0] opc);
    return (opc[5:4] == 2'b01) || (opc[3:0] == 4'd10) ||
           (opc[3:0] == 4'd11) || (opc[3:0] == 4'd15);
  endfunction

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } dec_state_e;

endpackage

// File: rtl/inst_decode_stage_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing bundle issues and cleared when writeback retires it.
module inst_scoreboard #(
  parameter int NREG = 32,
  parameter int RA_W = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_set_en,
  input  logic [RA_W-1:0] i_set_rd,
  input  logic            i_clr_en,
  input  logic [RA_W-1:0] i_clr_rd,
  input  logic            i_hold_wen,
  input  logic [RA_W-1:0] i_hold_rd,
  output logic [NREG-1:0] o_sb,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] sb_q, sb_d, hold_mask;

  // Next scoreboard: clear first so a same-register set in the same cycle wins.
  always_comb begin
    sb_d = sb_q;
    if (i_clr_en) sb_d[i_clr_rd] = 1'b0;
    if (i_set_en) sb_d[i_set_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sb_q <= '0;
    else          sb_q <= sb_d;
  end

  // The bundle still held at the output will write its destination too.
  always_comb begin
    hold_mask = '0;
    if (i_hold_wen) hold_mask[i_hold_rd] = 1'b1;
  end

  assign o_sb      = sb_q;
  assign o_pending = sb_q | hold_mask;

endmodule

// File: rtl/inst_decode_stage.sv
// Registered, flow-controlled decode stage with RAW/WAW hazard stalling,
// branch-unit flush and a halt opcode that freezes intake until reset.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int          INST_W   = 32,
  parameter int          NREG     = 32,
  parameter logic [5:0]  HALT_OPC = OPC_HALT,
  localparam int         RA_W     = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [INST_W-1:0]   i_inst,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [5:0]          o_opcode,
  output logic                o_type,
  output logic                o_branch,
  output logic [RA_W-1:0]     o_rs,
  output logic [RA_W-1:0]     o_rt,
  output logic [RA_W-1:0]     o_rd,
  output logic                o_wen,
  output logic signed [15:0]  o_imm,
  input  logic                i_flush,
  input  logic                i_wb_valid,
  input  logic [RA_W-1:0]     i_wb_rd,
  output logic                o_halted
);

  logic [5:0]         dec_opc;
  logic [RA_W-1:0]    dec_rs, dec_rt, dec_rd;
  logic               dec_rtype, dec_branch, dec_halt;
  logic               dec_rs_used, dec_rt_used, dec_wen;
  logic               hazard, accept, issue;
  logic [NREG-1:0]    pending, sb_unused;

  logic               valid_q, type_q, branch_q, wen_q;
  logic [5:0]         opcode_q;
  logic [RA_W-1:0]    rs_q, rt_q, rd_q;
  logic signed [15:0] imm_q;
  dec_state_e         state_q, state_d;
  logic               halted;

  assign dec_opc    = i_inst[31:26];
  assign dec_rs     = i_inst[21 +: RA_W];
  assign dec_rt     = i_inst[16 +: RA_W];
  assign dec_rtype  = is_rtype(dec_opc);
  assign dec_branch = is_branch(dec_opc);
  assign dec_halt   = (dec_opc == HALT_OPC);

  // Operand usage and destination by class; halt touches no registers.
  always_comb begin
    dec_rs_used = 1'b0;
    dec_rt_used = 1'b0;
    dec_rd      = '0;
    if (dec_halt) begin
      dec_rs_used = 1'b0;
    end else if (dec_branch) begin
      dec_rs_used = 1'b1;
      dec_rt_used = 1'b1;
    end else if (dec_rtype) begin
      dec_rs_used = 1'b1;
      dec_rt_used = 1'b1;
      dec_rd      = i_inst[11 +: RA_W];
    end else begin
      dec_rs_used = 1'b1;
      dec_rd      = dec_rt;
    end
  end

  assign dec_wen = (dec_rd != '0);

  // Only registered state feeds the hazard check; writeback is not bypassed.
  assign hazard = (dec_rs_used & pending[dec_rs]) |
                  (dec_rt_used & pending[dec_rt]) |
                  (dec_wen & pending[dec_rd]);

  assign o_ready = i_rst_n & (state_q == ST_RUN) & ~hazard &
                   (~valid_q | i_ready) & ~i_flush;
  assign accept  = i_valid & o_ready;
  // A flushed bundle is discarded, so a coincident i_ready does not issue it.
  assign issue   = valid_q & i_ready & ~i_flush;

  inst_scoreboard #(
    .NREG (NREG),
    .RA_W (RA_W)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set_en   (issue & wen_q),
    .i_set_rd   (rd_q),
    .i_clr_en   (i_wb_valid),
    .i_clr_rd   (i_wb_rd),
    .i_hold_wen (valid_q & wen_q),
    .i_hold_rd  (rd_q),
    .o_sb       (sb_unused),
    .o_pending  (pending)
  );

  // Output bundle register: load on accept, drop on issue or flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      type_q   <= 1'b0;
      branch_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      wen_q    <= 1'b0;
      imm_q    <= '0;
    end else if (i_flush) begin
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      opcode_q <= dec_opc;
      type_q   <= ~dec_rtype;
      branch_q <= dec_branch;
      rs_q     <= dec_rs;
      rt_q     <= dec_rt;
      rd_q     <= dec_rd;
      wen_q    <= dec_wen;
      imm_q    <= i_inst[15:0];
    end else if (issue) begin
      valid_q  <= 1'b0;
    end
  end

  // Halt FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // Halt FSM next state: pending until the halt bundle issues or is flushed.
  always_comb begin
    state_d = state_q;
    halted  = 1'b0;
    case (state_q)
      ST_RUN:       if (accept && dec_halt) state_d = ST_HALT_PEND;
      ST_HALT_PEND: begin
        if (i_flush)    state_d = ST_RUN;
        else if (issue) state_d = ST_HALTED;
      end
      ST_HALTED:    halted = 1'b1;
      default:      state_d = ST_RUN;
    endcase
  end

  assign o_valid  = valid_q;
  assign o_opcode = opcode_q;
  assign o_type   = type_q;
  assign o_branch = branch_q;
  assign o_rs     = rs_q;
  assign o_rt     = rt_q;
  assign o_rd     = rd_q;
  assign o_wen    = wen_q;
  assign o_imm    = imm_q;
  assign o_halted = halted;

endmodule
